// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone SRAM arbiter: FSM state codes and index helpers.
package wb_arb_pkg;

    localparam int MAX_MASTERS = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Index width for n masters; never zero so single-bit indices stay legal.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [2:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_sram_arbiter_rr_prio_enc.sv
// Round-robin priority encoder: picks the first requester after 'last', wrapping modulo N.
module rr_prio_enc
    import wb_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    localparam int PW = $clog2(2 * N);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [PW-1:0]  base;
    logic [IW-1:0]  pos;

    // rot[k] is the request k+1 places after 'last'; the doubled vector handles the wrap.
    assign req2 = {req, req};
    assign base = PW'(last) + PW'(1);

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot[gi] = req2[base + PW'(gi)];
    end

    always_comb begin
        grant = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos   = IW'((int'(last) + 1 + k) % N);
                grant = '0;
                grant[pos] = 1'b1;
            end
        end
    end

    assign idx = IW'(onehot2idx(MAX_MASTERS'(grant)));

endmodule

// File: rtl/wb_sram_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave among N_MASTERS masters, with ACK watchdog.
module wb_sram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTERS-1:0]           m_cyc,
    input  logic [N_MASTERS-1:0]           m_stb,
    input  logic [N_MASTERS-1:0]           m_we,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_adr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_dat_w,
    output logic [DATA_WIDTH-1:0]          m_dat_r,
    output logic [N_MASTERS-1:0]           m_ack,
    output logic [N_MASTERS-1:0]           m_err,
    output logic                           s_cyc,
    output logic                           s_stb,
    output logic                           s_we,
    output logic [ADDR_WIDTH-1:0]          s_adr,
    output logic [DATA_WIDTH-1:0]          s_dat_w,
    input  logic [DATA_WIDTH-1:0]          s_dat_r,
    input  logic                           s_ack,
    output logic [N_MASTERS-1:0]           gnt
);

    localparam int IW = idx_width(N_MASTERS);
    localparam int WW = $clog2(TIMEOUT) + 1;

    logic [0:0]           state_reg;
    logic [N_MASTERS-1:0] gnt_reg;
    logic [IW-1:0]        last_reg;
    logic [WW-1:0]        wdog_reg;

    logic [N_MASTERS-1:0] enc_grant;
    logic [IW-1:0]        enc_idx;
    logic                 cyc_g;
    logic                 stb_g;
    logic                 timeout;

    logic [ADDR_WIDTH-1:0] adr_arr [N_MASTERS];
    logic [DATA_WIDTH-1:0] dat_arr [N_MASTERS];

    rr_prio_enc #(.N(N_MASTERS)) u_enc (
        .req   (m_cyc),
        .last  (last_reg),
        .grant (enc_grant),
        .idx   (enc_idx)
    );

    // While granted, last_reg holds the owner's index, so it doubles as the mux select.
    assign cyc_g   = (state_reg == ST_GRANT) && m_cyc[last_reg];
    assign stb_g   = cyc_g && m_stb[last_reg];
    assign timeout = stb_g && !s_ack && (wdog_reg == WW'(TIMEOUT - 1));

    assign s_cyc   = cyc_g && !timeout;
    assign s_stb   = stb_g && !timeout;
    assign s_we    = cyc_g && m_we[last_reg];
    assign s_adr   = adr_arr[last_reg];
    assign s_dat_w = dat_arr[last_reg];
    assign m_dat_r = s_dat_r;
    assign gnt     = gnt_reg;

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_mst
        assign adr_arr[gi] = m_adr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign dat_arr[gi] = m_dat_w[gi*DATA_WIDTH +: DATA_WIDTH];
        assign m_ack[gi]   = gnt_reg[gi] && cyc_g && s_ack;
        assign m_err[gi]   = gnt_reg[gi] && timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            last_reg  <= IW'(N_MASTERS - 1);
            wdog_reg  <= '0;
        end else if (state_reg == ST_IDLE) begin
            wdog_reg <= '0;
            if (|m_cyc) begin
                state_reg <= ST_GRANT;
                gnt_reg   <= enc_grant;
                last_reg  <= enc_idx;
            end
        end else if (!cyc_g || timeout) begin
            // Any ACK arriving after this point finds IDLE and is never routed.
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            wdog_reg  <= '0;
        end else if (s_ack) begin
            wdog_reg <= '0;
        end else if (stb_g) begin
            wdog_reg <= wdog_reg + WW'(1);
        end
    end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Self-checking bench for wb_sram_arbiter: vector table, hand-written corner sequences, random traffic.
module tb_wb_sram_arbiter;

    localparam int N     = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TO    = 16;
    localparam int NOACK = 255;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N*AW-1:0] m_adr = '0;
    logic [N*DW-1:0] m_dat_w = '0;
    logic [DW-1:0]   m_dat_r;
    logic [N-1:0]    m_ack, m_err, gnt;
    logic            s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_w, s_dat_r;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb_sram_arbiter #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err), .s_cyc(s_cyc),
        .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .gnt(gnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // SRAM slave: registered ACK after wait_n extra STB cycles; late_ack injects a stray ACK.
    logic [31:0] slave_mem [256];
    logic [31:0] ref_mem   [256];
    logic ack_r = 1'b0;
    logic late_ack = 1'b0;
    int   wait_n = 0;
    int   wcnt = 0;
    assign s_ack   = ack_r || late_ack;
    assign s_dat_r = slave_mem[s_adr[9:2]];

    always @(posedge clk) begin
        bit nxt;
        nxt = 1'b0;
        if (rst) wcnt = 0;
        else if (s_cyc && s_stb && !s_ack) begin
            if (wcnt >= wait_n) begin nxt = 1'b1; wcnt = 0; end
            else wcnt++;
        end else wcnt = 0;
        if (!rst && s_cyc && s_stb && s_ack && s_we) slave_mem[s_adr[9:2]] = s_dat_w;
        #1 ack_r = nxt;
    end

    // Grant monitor: order of new grants and the idle cycles preceding each one.
    int glog[$];
    int gaps[$];
    int zero_run = 0;
    logic [N-1:0] prev_gnt = '0;

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    always @(negedge clk) begin
        if (gnt != '0 && gnt != prev_gnt) begin
            glog.push_back(oh_idx(gnt));
            gaps.push_back(zero_run);
        end
        if (gnt == '0) zero_run++;
        else zero_run = 0;
        prev_gnt = gnt;
        if (!rst && (m_ack | m_err) != '0) chk("resp_only_to_owner", 32'((m_ack | m_err) & ~gnt), 32'h0);
    end

    function automatic int rr_next(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic note_write(input logic [31:0] adr, input logic [31:0] dat, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = adr + 32'(4 * i);
            ref_mem[a[9:2]] = dat + 32'(i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; late_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        glog.delete(); gaps.delete();
    endtask

    // One CYC cycle of n transfers from master m; reports acks, errors, granted cycles, s_cyc latency.
    task automatic burst(input int m, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input int n, output logic [31:0] rd, output int acks, output int errs,
                         output int gcyc, output int lat, output logic [N-1:0] gnt_seen,
                         output logic scyc_end);
        int  waited;
        bit  done;
        acks = 0; errs = 0; gcyc = 0; lat = 0; rd = '0; gnt_seen = '0; scyc_end = 1'b1; waited = 0;
        m_cyc[m] = 1'b1;
        m_we[m]  = we;
        for (int i = 0; i < n && errs == 0; i++) begin
            m_adr[m*AW +: AW]   = adr + 32'(4 * i);
            m_dat_w[m*DW +: DW] = dat + 32'(i);
            m_stb[m] = 1'b1;
            done = 1'b0;
            while (!done && waited < 400) begin
                @(negedge clk);
                waited++;
                if (gnt[m]) gcyc++;
                if (lat == 0 && s_cyc && gnt[m]) lat = waited;
                if (m_ack[m]) begin done = 1'b1; acks++; rd = m_dat_r; gnt_seen = gnt; end
                else if (m_err[m]) begin done = 1'b1; errs++; scyc_end = s_cyc; end
            end
            @(posedge clk);
            #1;
        end
        m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
    endtask

    task automatic master_loop(input int m);
        logic [31:0] rd; int a, e, g, l; logic [N-1:0] gs; logic se;
        for (int k = 0; k < 2; k++) begin
            burst(m, 1'b1, 32'h80 + 32'(m * 8 + 4 * k), 32'hA000 + 32'(m * 16 + k), 1, rd, a, e, g, l, gs, se);
            chk($sformatf("rr_ack_m%0d_%0d", m, k), 32'(a), 32'd1);
            note_write(32'h80 + 32'(m * 8 + 4 * k), 32'hA000 + 32'(m * 16 + k), 1);
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        int          m;
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] exp_rd;
        logic [N-1:0] exp_gnt;
    } vec_t;

    vec_t tv [6];

    initial begin
        logic [31:0] rd, rd1, a32, d32;
        int a0, e0, g0, l0, a1, e1, g1, l1, rm, rlast;
        logic [N-1:0] gs0, gs1, rreq;
        logic se0, se1;
        bit rwe;
        int remaining [N];
        int exp_order[$];

        tv[0] = '{m:0, we:1'b1, adr:32'h10, dat:32'hDEADBEEF, exp_rd:32'h0,        exp_gnt:3'b001};
        tv[1] = '{m:0, we:1'b0, adr:32'h10, dat:32'h0,        exp_rd:32'hDEADBEEF, exp_gnt:3'b001};
        tv[2] = '{m:1, we:1'b1, adr:32'h20, dat:32'h12345678, exp_rd:32'h0,        exp_gnt:3'b010};
        tv[3] = '{m:2, we:1'b0, adr:32'h20, dat:32'h0,        exp_rd:32'h12345678, exp_gnt:3'b100};
        tv[4] = '{m:2, we:1'b1, adr:32'h10, dat:32'hCAFEF00D, exp_rd:32'h0,        exp_gnt:3'b100};
        tv[5] = '{m:1, we:1'b0, adr:32'h10, dat:32'h0,        exp_rd:32'hCAFEF00D, exp_gnt:3'b010};

        for (int i = 0; i < 256; i++) begin slave_mem[i] = '0; ref_mem[i] = '0; end

        // Reset state, with a master already requesting.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_s_cyc_stb_we", {29'd0, s_cyc, s_stb, s_we}, 32'h0);
        chk("rst_m_ack_err", {26'd0, m_ack, m_err}, 32'h0);
        do_reset();

        // Vector table of isolated single transfers.
        for (int i = 0; i < 6; i++) begin
            burst(tv[i].m, tv[i].we, tv[i].adr, tv[i].dat, 1, rd, a0, e0, g0, l0, gs0, se0);
            chk($sformatf("tv%0d_ack", i), 32'(a0), 32'd1);
            chk($sformatf("tv%0d_latency", i), 32'(l0), 32'd2);
            chk($sformatf("tv%0d_gnt", i), 32'(gs0), 32'(tv[i].exp_gnt));
            if (tv[i].we) note_write(tv[i].adr, tv[i].dat, 1);
            else chk($sformatf("tv%0d_rdata", i), rd, tv[i].exp_rd);
            @(posedge clk);
            #1;
        end

        // Simultaneous requests from m0 and m1 after reset.
        do_reset();
        fork
            burst(0, 1'b1, 32'h40, 32'h1111, 1, rd, a0, e0, g0, l0, gs0, se0);
            burst(1, 1'b1, 32'h44, 32'h2222, 1, rd1, a1, e1, g1, l1, gs1, se1);
        join
        note_write(32'h40, 32'h1111, 1);
        note_write(32'h44, 32'h2222, 1);
        chk("tie_acks", 32'(a0 + a1), 32'd2);
        chk("tie_first", 32'(q_at(glog, 0)), 32'd0);
        chk("tie_second", 32'(q_at(glog, 1)), 32'd1);
        chk("tie_idle_gap", 32'(q_at(gaps, 1)), 32'd1);

        // All masters contend, two transfers each; order from the round-robin rule.
        do_reset();
        for (int i = 0; i < N; i++) remaining[i] = 2;
        rlast = N - 1;
        exp_order.delete();
        for (int t = 0; t < 2 * N; t++) begin
            for (int i = 0; i < N; i++) rreq[i] = (remaining[i] > 0);
            rm = rr_next(rlast, rreq);
            exp_order.push_back(rm);
            remaining[rm]--;
            rlast = rm;
        end
        fork
            master_loop(0);
            master_loop(1);
            master_loop(2);
        join
        chk("rr_grant_count", 32'(glog.size()), 32'(2 * N));
        for (int i = 0; i < 2 * N; i++) begin
            chk($sformatf("rr_order_%0d", i), 32'(q_at(glog, i)), 32'(exp_order[i]));
            if (i > 0) chk($sformatf("rr_gap_%0d", i), 32'(q_at(gaps, i)), 32'd1);
        end

        // m1 holds CYC for a 4-write burst while m0 waits.
        do_reset();
        fork
            burst(1, 1'b1, 32'h100, 32'h5000, 4, rd1, a1, e1, g1, l1, gs1, se1);
            begin
                @(posedge clk);
                #1;
                burst(0, 1'b1, 32'h200, 32'h6000, 1, rd, a0, e0, g0, l0, gs0, se0);
            end
        join
        note_write(32'h100, 32'h5000, 4);
        note_write(32'h200, 32'h6000, 1);
        chk("hold_m1_acks", 32'(a1), 32'd4);
        chk("hold_m0_acks", 32'(a0), 32'd1);
        chk("hold_order0", 32'(q_at(glog, 0)), 32'd1);
        chk("hold_order1", 32'(q_at(glog, 1)), 32'd0);
        @(posedge clk);
        #1;
        burst(2, 1'b0, 32'h10C, 32'h0, 1, rd, a0, e0, g0, l0, gs0, se0);
        chk("hold_readback", rd, ref_mem[32'h10C >> 2]);

        // Watchdog: no ACK, ERR on the 16th STB cycle, stray ACK afterwards dropped.
        do_reset();
        wait_n = NOACK;
        burst(0, 1'b0, 32'h10, 32'h0, 1, rd, a0, e0, g0, l0, gs0, se0);
        chk("wd_err", 32'(e0), 32'd1);
        chk("wd_no_ack", 32'(a0), 32'd0);
        chk("wd_stb_cycles", 32'(g0), 32'(TO));
        chk("wd_s_cyc_at_err", 32'(se0), 32'd0);
        late_ack = 1'b1;
        @(negedge clk);
        chk("wd_late_ack_dropped", 32'(m_ack), 32'h0);
        @(posedge clk);
        #1 late_ack = 1'b0;
        wait_n = 0;
        burst(0, 1'b0, 32'h10, 32'h0, 1, rd, a0, e0, g0, l0, gs0, se0);
        chk("wd_next_ack", 32'(a0), 32'd1);
        chk("wd_next_rdata", rd, ref_mem[32'h10 >> 2]);
        @(posedge clk);
        #1;
        wait_n = TO - 2;
        burst(1, 1'b0, 32'h20, 32'h0, 1, rd, a1, e1, g1, l1, gs1, se1);
        chk("wd_ack_wins_ack", 32'(a1), 32'd1);
        chk("wd_ack_wins_no_err", 32'(e1), 32'd0);
        chk("wd_ack_wins_cycles", 32'(g1), 32'(TO));
        wait_n = 0;
        @(posedge clk);
        #1;

        // Random single transfers against the reference memory.
        for (int t = 0; t < 30; t++) begin
            rm = $urandom_range(N - 1, 0);
            rwe = 1'($urandom_range(1, 0));
            a32 = 32'($urandom_range(15, 0)) << 2;
            d32 = $urandom;
            wait_n = $urandom_range(3, 0);
            burst(rm, rwe, a32, d32, 1, rd, a0, e0, g0, l0, gs0, se0);
            chk($sformatf("rand%0d_ack", t), 32'(a0), 32'd1);
            if (rwe) note_write(a32, d32, 1);
            else chk($sformatf("rand%0d_rdata", t), rd, ref_mem[a32[9:2]]);
            @(posedge clk);
            #1;
        end
        wait_n = 0;

        // Reset in the middle of a stalled transfer.
        do_reset();
        wait_n = NOACK;
        m_adr[1*AW +: AW] = 32'h30;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mid_gnt_before", 32'(gnt), 32'h2);
        chk("mid_s_cyc_before", 32'(s_cyc), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_s_cyc", 32'(s_cyc), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_after_gnt", 32'(gnt), 32'h1);
        chk("mid_after_s_cyc", 32'(s_cyc), 32'd1);
        m_cyc = '0; m_stb = '0;
        wait_n = 0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
